// File: rtl/pipeif_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface pipeif_fetch_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage: PC, imem handshake, one-entry skid buffer and IF/ID register
// with delayed-branch redirect that survives a late delay-slot fetch.
module pipeif_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    input  logic        nostall,
    pipeif_fetch_if.master imem,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        dvalid
);
    localparam int unsigned XLEN = 32;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] dpc4_q, dpc4_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            dvalid_q, dvalid_d;
    logic [XLEN-1:0] hinst_q, hinst_d;
    logic [XLEN-1:0] hpc4_q, hpc4_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;

    logic            accept;
    logic            redir;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] npc;

    // Redirect decode; a live redirect overrides one parked while the delay slot was late.
    always_comb begin
        target = pc_q + XLEN'(4);
        case (pcsource)
            2'b01:   target = bpc;
            2'b10:   target = da;
            2'b11:   target = jpc;
            default: target = pc_q + XLEN'(4);
        endcase
        pc_plus4 = pc_q + XLEN'(4);
        accept   = !dvalid_q || nostall;
        redir    = dvalid_q && nostall && (pcsource != 2'b00);
        if (redir) begin
            npc = target;
        end else if (pend_q) begin
            npc = pend_pc_q;
        end else begin
            npc = pc_plus4;
        end
    end

    assign imem.imem_req  = (state_q == S_REQ) && !clr;
    assign imem.imem_addr = pc_q;

    assign pc     = pc_q;
    assign dpc4   = dpc4_q;
    assign inst   = inst_q;
    assign dvalid = dvalid_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            dpc4_q    <= '0;
            inst_q    <= '0;
            dvalid_q  <= 1'b0;
            hinst_q   <= '0;
            hpc4_q    <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            dpc4_q    <= dpc4_d;
            inst_q    <= inst_d;
            dvalid_q  <= dvalid_d;
            hinst_q   <= hinst_d;
            hpc4_q    <= hpc4_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        dpc4_d    = dpc4_q;
        inst_d    = inst_q;
        dvalid_d  = dvalid_q;
        hinst_d   = hinst_q;
        hpc4_d    = hpc4_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;

        case (state_q)
            S_REQ: begin
                if (imem.imem_ready) begin
                    if (accept) begin
                        inst_d   = imem.imem_rdata;
                        dpc4_d   = pc_plus4;
                        dvalid_d = 1'b1;
                        pc_d     = npc;
                        pend_d   = 1'b0;
                    end else begin
                        hinst_d = imem.imem_rdata;
                        hpc4_d  = pc_plus4;
                        state_d = S_HOLD;
                    end
                end else begin
                    // Decode drains with nothing to replace it: insert a nop bubble.
                    if (nostall && dvalid_q) begin
                        inst_d   = '0;
                        dvalid_d = 1'b0;
                    end
                    if (redir) begin
                        pend_d    = 1'b1;
                        pend_pc_d = target;
                    end
                end
            end
            S_HOLD: begin
                if (accept) begin
                    inst_d   = hinst_q;
                    dpc4_d   = hpc4_q;
                    dvalid_d = 1'b1;
                    pc_d     = npc;
                    pend_d   = 1'b0;
                    state_d  = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end
endmodule

// File: tb/tb_pipeif_fetch.sv
// Bench for pipeif_fetch: directed per-cycle vector table, wrap check, and a randomized
// run checked against a program-order model of delayed-branch fetch.
module tb_pipeif_fetch;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic        clr = 1'b1;
    logic        nostall = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'h100, da = 32'h200, jpc = 32'h300;
    logic [31:0] pc, dpc4, inst;
    logic        dvalid;
    pipeif_fetch_if mif();

    pipeif_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .clr(clr), .pcsource(pcsource), .bpc(bpc), .da(da), .jpc(jpc),
        .nostall(nostall), .imem(mif), .pc(pc), .dpc4(dpc4), .inst(inst), .dvalid(dvalid)
    );

    // Wrap DUT (RESET_PC = 0xFFFF_FFFC)
    logic        w_clr = 1'b1;
    logic        w_nostall = 1'b0;
    logic [1:0]  w_pcsource = 2'b00;
    logic [31:0] w_bpc = 32'h0, w_da = 32'h0, w_jpc = 32'h0;
    logic [31:0] w_pc, w_dpc4, w_inst;
    logic        w_dvalid;
    pipeif_fetch_if wif();

    pipeif_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .clr(w_clr), .pcsource(w_pcsource), .bpc(w_bpc), .da(w_da), .jpc(w_jpc),
        .nostall(w_nostall), .imem(wif), .pc(w_pc), .dpc4(w_dpc4), .inst(w_inst),
        .dvalid(w_dvalid)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a | 32'h1000_0000;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One row = one clock cycle: inputs for the cycle and outputs seen before its edge.
    typedef struct {
        logic        clr;
        logic        ns;
        logic        rdy;
        logic [1:0]  ps;
        int          lvl;   // 0 none, 1 imem_req only, 2 everything
        logic        req;
        logic [31:0] addr;
        logic        dv;
        logic [31:0] inst;
        logic [31:0] dpc4;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic c, input logic n, input logic r, input logic [1:0] p,
                       input int l, input logic rq, input logic [31:0] ad, input logic v,
                       input logic [31:0] in, input logic [31:0] d4);
        vec_t t;
        t.clr = c; t.ns = n; t.rdy = r; t.ps = p; t.lvl = l; t.req = rq;
        t.addr = ad; t.dv = v; t.inst = in; t.dpc4 = d4;
        vq.push_back(t);
    endtask

    // Branch at 0x8 whose delay slot (0xC) comes back three cycles late.
    task automatic late_seq(input logic [1:0] p, input logic [31:0] tgt);
        add(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 2, 1, 32'h0, 0, 0, 0);
        add(0, 1, 1, 0, 2, 1, 32'h4, 1, mem_word(32'h0), 32'h4);
        add(0, 1, 1, 0, 2, 1, 32'h8, 1, mem_word(32'h4), 32'h8);
        add(0, 1, 0, p, 2, 1, 32'hC, 1, mem_word(32'h8), 32'hC);
        add(0, 1, 0, p, 2, 1, 32'hC, 0, 0, 32'hC);
        add(0, 1, 0, p, 2, 1, 32'hC, 0, 0, 32'hC);
        add(0, 1, 1, 0, 2, 1, 32'hC, 0, 0, 32'hC);
        add(0, 1, 1, 0, 2, 1, tgt, 1, mem_word(32'hC), 32'h10);
        add(0, 1, 0, 0, 2, 1, tgt + 32'h4, 1, mem_word(tgt), tgt + 32'h4);
    endtask

    initial begin
        logic [31:0] exp_next;
        logic [31:0] br_tgt;
        logic [31:0] req_addr;
        bit          in_delay;
        bit          outst;
        int          lat;
        int          idle;
        int          consumed;

        mif.imem_ready = 1'b0;
        mif.imem_rdata = '0;
        wif.imem_ready = 1'b0;
        wif.imem_rdata = '0;

        // Reset with late ready, zero-wait stream, 3-cycle stall, reset mid-request, timely branch.
        add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 2, 0, 32'h0, 0, 0, 0);
        add(0, 1, 1, 0, 2, 1, 32'h0, 0, 0, 0);
        add(0, 1, 1, 0, 2, 1, 32'h4, 1, mem_word(32'h0), 32'h4);
        add(0, 1, 1, 0, 2, 1, 32'h8, 1, mem_word(32'h4), 32'h8);
        add(0, 0, 1, 0, 2, 1, 32'hC, 1, mem_word(32'h8), 32'hC);
        add(0, 0, 1, 0, 2, 0, 32'hC, 1, mem_word(32'h8), 32'hC);
        add(0, 0, 1, 0, 2, 0, 32'hC, 1, mem_word(32'h8), 32'hC);
        add(0, 1, 0, 0, 2, 0, 32'hC, 1, mem_word(32'h8), 32'hC);
        add(0, 1, 1, 0, 2, 1, 32'h10, 1, mem_word(32'hC), 32'h10);
        add(1, 1, 1, 0, 2, 0, 32'h14, 1, mem_word(32'h10), 32'h14);
        add(0, 1, 0, 0, 2, 1, 32'h0, 0, 0, 0);
        add(0, 1, 1, 0, 2, 1, 32'h0, 0, 0, 0);
        add(0, 1, 1, 0, 2, 1, 32'h4, 1, mem_word(32'h0), 32'h4);
        add(0, 1, 1, 0, 2, 1, 32'h8, 1, mem_word(32'h4), 32'h8);
        add(0, 1, 1, 1, 2, 1, 32'hC, 1, mem_word(32'h8), 32'hC);
        add(0, 1, 1, 0, 2, 1, 32'h100, 1, mem_word(32'hC), 32'h10);
        add(0, 1, 0, 0, 2, 1, 32'h104, 1, mem_word(32'h100), 32'h104);
        late_seq(2'b01, 32'h100);
        late_seq(2'b10, 32'h200);
        late_seq(2'b11, 32'h300);

        foreach (vq[i]) begin
            @(negedge clk);
            clr            = vq[i].clr;
            nostall        = vq[i].ns;
            pcsource       = vq[i].ps;
            mif.imem_ready = vq[i].rdy;
            mif.imem_rdata = mem_word(mif.imem_addr);
            #1;
            if (vq[i].lvl >= 1)
                chk32($sformatf("row%0d_req", i), 32'(mif.imem_req), 32'(vq[i].req));
            if (vq[i].lvl >= 2) begin
                chk32($sformatf("row%0d_addr", i), mif.imem_addr, vq[i].addr);
                chk32($sformatf("row%0d_dvalid", i), 32'(dvalid), 32'(vq[i].dv));
                chk32($sformatf("row%0d_inst", i), inst, vq[i].inst);
                chk32($sformatf("row%0d_dpc4", i), dpc4, vq[i].dpc4);
            end
        end

        // PC wrap from 0xFFFF_FFFC to 0.
        @(negedge clk);
        w_clr = 1'b0;
        w_nostall = 1'b1;
        wif.imem_ready = 1'b1;
        wif.imem_rdata = mem_word(wif.imem_addr);
        #1;
        chk32("wrap_req", 32'(wif.imem_req), 32'h1);
        chk32("wrap_addr0", wif.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        wif.imem_rdata = mem_word(wif.imem_addr);
        #1;
        chk32("wrap_addr1", wif.imem_addr, 32'h0);
        chk32("wrap_dpc4", w_dpc4, 32'h0);
        chk32("wrap_dvalid", 32'(w_dvalid), 32'h1);
        chk32("wrap_inst", w_inst, mem_word(32'hFFFF_FFFC));
        w_clr = 1'b1;

        // Randomized run: variable-latency memory, random stalls and redirects.
        @(negedge clk);
        clr = 1'b1;
        pcsource = 2'b00;
        @(negedge clk);
        exp_next = 32'h0;
        br_tgt   = 32'h0;
        req_addr = 32'h0;
        in_delay = 1'b0;
        outst    = 1'b0;
        lat      = 0;
        idle     = 0;
        consumed = 0;
        clr      = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (mif.imem_req) begin
                if (!outst) begin
                    outst    = 1'b1;
                    lat      = int'($urandom_range(0, 3));
                    req_addr = mif.imem_addr;
                end else begin
                    chk32("rnd_addr_stable", mif.imem_addr, req_addr);
                end
                mif.imem_ready = (lat == 0);
                mif.imem_rdata = mem_word(mif.imem_addr);
                if (lat == 0) outst = 1'b0;
                else          lat--;
            end else begin
                mif.imem_ready = 1'($urandom_range(0, 1));
                mif.imem_rdata = $urandom;
            end

            nostall  = ($urandom_range(0, 9) < 7);
            bpc      = 32'($urandom_range(0, 16'hFFFF)) << 2;
            da       = 32'($urandom_range(0, 16'hFFFF)) << 2;
            jpc      = 32'($urandom_range(0, 16'hFFFF)) << 2;
            pcsource = 2'($urandom_range(0, 3));

            if (dvalid == 1'b0) chk32("rnd_bubble_nop", inst, 32'h0);

            if (dvalid && nostall) begin
                chk32("rnd_dpc4", dpc4, exp_next + 32'h4);
                chk32("rnd_inst", inst, mem_word(exp_next));
                if (in_delay) begin
                    pcsource = 2'b00;
                    exp_next = br_tgt;
                    in_delay = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    pcsource = 2'($urandom_range(1, 3));
                    case (pcsource)
                        2'b01:   br_tgt = bpc;
                        2'b10:   br_tgt = da;
                        default: br_tgt = jpc;
                    endcase
                    exp_next = exp_next + 32'h4;
                    in_delay = 1'b1;
                end else begin
                    pcsource = 2'b00;
                    exp_next = exp_next + 32'h4;
                end
                idle = 0;
                consumed++;
            end else begin
                idle++;
            end
            if (idle > 60) begin
                checks++;
                errors++;
                $display("FAIL rnd_progress: got %0d idle cycles, required at most 60", idle);
                break;
            end
        end
        checks++;
        if (consumed < 300) begin
            errors++;
            $display("FAIL rnd_throughput: got %0d instructions, required at least 300", consumed);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeif_fetch.md
# pipeif_fetch

Instruction-fetch stage of the five-stage pipelined CPU; the upstream end of the IF→ID interface. Holds the PC, runs a req/ready handshake to a variable-latency instruction memory, and drives the IF/ID pipeline register (`dpc4`, `inst`) consumed by the decode stage. Takes the decode stage's redirect outputs (`pcsource`, `bpc`, `jpc`, register operand `da`) and its `nostall`, and implements delayed-branch semantics even when the delay-slot fetch is late.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `clk` in 1: clock, all state updates on rising edge.
- `clr` in 1: synchronous, active-high reset.
- `pcsource` in 2: from decode; 00 pc+4, 01 `bpc`, 10 `da`, 11 `jpc`.
- `bpc` in 32: branch target from decode.
- `da` in 32: jr target (forwarded rs operand) from decode.
- `jpc` in 32: jump target from decode.
- `nostall` in 1: 1 = decode consumes IF/ID contents this cycle.
- `imem_ready` in 1: instruction memory response valid.
- `imem_rdata` in 32: instruction word, valid with `imem_ready`.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address (= `pc`).
- `pc` out 32: current fetch PC.
- `dpc4` out 32: IF/ID register, PC+4 of `inst`.
- `inst` out 32: IF/ID register, instruction to decode.
- `dvalid` out 1: IF/ID register holds a real instruction.

## Operation
- States: REQ (request outstanding), HOLD (fetched word parked in skid buffer `hinst`/`hpc4`, `imem_req`=0).
- `accept` = `!dvalid || nostall` (IF/ID can load this cycle).
- `redir` = `dvalid && nostall && pcsource != 00`; target = mux(`pcsource`).
- `npc` on a load into IF/ID: `redir` ? live target : `pend` ? `pend_pc` : pc+4.
- REQ: `imem_req`=1, `imem_addr`=`pc`, stable until `imem_ready`.
  - ready & accept: `inst`<=`imem_rdata`, `dpc4`<=pc+4, `dvalid`<=1, `pc`<=`npc`, `pend`<=0; stay REQ.
  - ready & !accept: `hinst`<=`imem_rdata`, `hpc4`<=pc+4; go HOLD.
  - !ready & nostall & dvalid: bubble; `inst`<=0 (nop), `dvalid`<=0.
  - !ready & redir: `pend`<=1, `pend_pc`<=target (branch leaves decode before its delay slot arrives).
- HOLD: when accept, IF/ID <= `hinst`/`hpc4`, `dvalid`<=1, `pc`<=`npc`, `pend`<=0, go REQ. Otherwise hold everything.
- Delay slot always executes; instruction after it is fetched from the redirect target.
- `pcsource`/targets ignored unless `redir`; `imem_ready` ignored in HOLD and during `clr`.
- No instruction is lost or duplicated; program order preserved across stalls.

## Timing
- Reset (`clr`=1 at edge): `pc`=`RESET_PC`, `dvalid`=0, `inst`=0, `dpc4`=0, `pend`=0, state REQ, `hinst`/`hpc4`=0. `imem_req`=0 while `clr`=1; rises combinationally first cycle after `clr` low.
- Reset mid-request: outstanding fetch abandoned; late `imem_ready` during `clr` discarded; refetch from `RESET_PC`.
- Zero-wait memory (`imem_ready` same cycle as req): one instruction per cycle; `inst` valid cycle after ready.
- `imem_req`/`imem_addr` combinational from state and `pc`.
- Stall: IF/ID, `pc` frozen while `dvalid && !nostall`; at most one word parked in HOLD.
- Simultaneous `redir` and load: live target wins over `pend`.
- `pc` wraps modulo 2^32 (0xFFFF_FFFC+4 = 0); no alignment checks.

## Test plan
- Reset: `clr` 2 cycles with `imem_ready`=1 -> `imem_req`=0, `dvalid`=0, `inst`=0; next cycle `imem_req`=1, `imem_addr`=0.
- Zero-wait stream, `nostall`=1, `imem_rdata`=addr|0x1000_0000 -> `inst` 0x1000_0000, 0x1000_0004, 0x1000_0008 on consecutive cycles, `dpc4`=4,8,12.
- Stall: `nostall`=0 for 3 cycles while `dvalid` -> `inst`/`dpc4` held, state HOLD, `imem_req`=0; after release, parked word then next word, no gap in sequence.
- Timely branch: instr at 0x8 in decode with `pcsource`=01, `bpc`=0x100 while delay slot 0xC returns -> next `imem_addr`=0x100; `inst` order 0x8, 0xC, then word@0x100.
- Late delay slot: same branch, delay-slot ready delayed 3 cycles -> `dvalid`=0/`inst`=0 bubbles, `pend`=1; delay slot 0xC delivered, then `imem_addr`=0x100. Repeat with `pcsource`=10, `da`=0x200 and 11, `jpc`=0x300.
- Wrap: `RESET_PC`=0xFFFF_FFFC -> second fetch `imem_addr`=0, `dpc4`=0.
